// File: rtl/blink_sequencer.sv
// rtl/blink_sequencer.sv - command-driven LED blink sequencer with built-in tick prescaler
module blink_sequencer #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_on_ticks,
  input  logic [7:0] cmd_off_ticks,
  input  logic [7:0] cmd_count,
  input  logic       abort,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    phase, phase_n;
  logic [7:0]    blinks, blinks_n;
  logic [7:0]    on_r, on_n;
  logic [7:0]    off_r, off_n;
  logic          led_n, busy_n, done_n, aborted_n;
  logic          tick;

  assign cmd_ready = !busy;
  assign tick      = (presc == PRESC_MAX);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      presc   <= '0;
      phase   <= '0;
      blinks  <= '0;
      on_r    <= '0;
      off_r   <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      phase   <= phase_n;
      blinks  <= blinks_n;
      on_r    <= on_n;
      off_r   <= off_n;
      led     <= led_n;
      busy    <= busy_n;
      done    <= done_n;
      aborted <= aborted_n;
    end
  end

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    phase_n   = phase;
    blinks_n  = blinks;
    on_n      = on_r;
    off_n     = off_r;
    led_n     = led;
    busy_n    = busy;
    done_n    = 1'b0;
    aborted_n = 1'b0;

    if (state != IDLE) presc_n = tick ? '0 : presc + PW'(1);

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_count == 8'd0 || cmd_on_ticks == 8'd0) begin
            done_n = 1'b1;
          end else begin
            state_n  = ON;
            presc_n  = '0;
            phase_n  = cmd_on_ticks;
            blinks_n = cmd_count;
            on_n     = cmd_on_ticks;
            off_n    = (cmd_off_ticks == 8'd0) ? 8'd1 : cmd_off_ticks;
            led_n    = 1'b1;
            busy_n   = 1'b1;
          end
        end
      end
      ON, OFF: begin
        // abort outranks any tick, including the final one of the sequence
        if (abort) begin
          state_n   = IDLE;
          presc_n   = '0;
          led_n     = 1'b0;
          busy_n    = 1'b0;
          aborted_n = 1'b1;
        end else if (tick) begin
          if (phase != 8'd1) begin
            phase_n = phase - 8'd1;
          end else if (state == ON) begin
            state_n = OFF;
            phase_n = off_r;
            led_n   = 1'b0;
          end else if (blinks == 8'd1) begin
            state_n = IDLE;
            presc_n = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n  = ON;
            blinks_n = blinks - 8'd1;
            phase_n  = on_r;
            led_n    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// tb/tb_blink_sequencer.sv - bench for blink_sequencer at TICK_DIV=4 and TICK_DIV=1
module tb_blink_sequencer;

  typedef struct {
    bit v;
    int base;
    int on;
    int off;
    int cnt;
    int ab;
  } seq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  logic       cmd_valid4 = 1'b0, abort4 = 1'b0;
  logic [7:0] on4 = '0, off4 = '0, cnt4 = '0;
  logic       cmd_ready4, led4, busy4, done4, aborted4;
  logic       cmd_valid1 = 1'b0, abort1 = 1'b0;
  logic [7:0] on1 = '0, off1 = '0, cnt1 = '0;
  logic       cmd_ready1, led1, busy1, done1, aborted1;

  seq_t s4[2];
  seq_t s1[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blink_sequencer #(.TICK_DIV(4)) u4 (
    .clk_in(clk), .rst_n(rst_n), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_on_ticks(on4), .cmd_off_ticks(off4), .cmd_count(cnt4), .abort(abort4),
    .led(led4), .busy(busy4), .done(done4), .aborted(aborted4)
  );

  blink_sequencer #(.TICK_DIV(1)) u1 (
    .clk_in(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_on_ticks(on1), .cmd_off_ticks(off1), .cmd_count(cnt1), .abort(abort1),
    .led(led1), .busy(busy1), .done(done1), .aborted(aborted1)
  );

  // {led, busy, done, aborted, 0} for one accepted command, from its cycle-0 index
  function automatic logic [4:0] seq_out(seq_t s, int t_abs, int td);
    int t, offe, per, tot;
    bit hit;
    logic l, b, d, a;
    l = 0; b = 0; d = 0; a = 0;
    if (s.v) begin
      t = t_abs - s.base;
      offe = (s.off == 0) ? 1 : s.off;
      if (s.cnt == 0 || s.on == 0) begin
        d = (t == 1);
      end else begin
        per = (s.on + offe) * td;
        tot = s.cnt * per;
        hit = (s.ab >= 1) && (s.ab <= tot);
        if (t >= 1 && t <= tot && !(hit && t > s.ab)) begin
          b = 1;
          l = ((t - 1) % per) < (s.on * td);
        end
        d = (t == tot + 1) && !hit;
        a = hit && (t == s.ab + 1);
      end
    end
    return {l, b, d, a, 1'b0};
  endfunction

  function automatic logic [4:0] model(seq_t a, seq_t b, int t_abs, int td);
    logic [4:0] o;
    o = seq_out(a, t_abs, td) | seq_out(b, t_abs, td);
    o[0] = !o[3];
    return o;
  endfunction

  always @(negedge clk) begin
    logic [4:0] e4, e1, g4, g1;
    if (chk_en) begin
      e4 = model(s4[0], s4[1], cyc, 4);
      e1 = model(s1[0], s1[1], cyc, 1);
      g4 = {led4, busy4, done4, aborted4, cmd_ready4};
      g1 = {led1, busy1, done1, aborted1, cmd_ready1};
      tests += 2;
      if (g4 !== e4) begin
        fails++;
        $display("FAIL u4 cycle %0d {led,busy,done,aborted,ready} got %b want %b", cyc, g4, e4);
      end
      if (g1 !== e1) begin
        fails++;
        $display("FAIL u1 cycle %0d {led,busy,done,aborted,ready} got %b want %b", cyc, g1, e1);
      end
    end
  end

  task automatic check(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_slot4(input int idx, input int base, input int on, input int off,
                           input int cnt, input int ab);
    s4[idx].v = 1; s4[idx].base = base; s4[idx].on = on;
    s4[idx].off = off; s4[idx].cnt = cnt; s4[idx].ab = ab;
  endtask

  // drives one command during the current cycle, then scrambles the fields
  task automatic issue4(input int on, input int off, input int cnt, input int ab, output int base);
    base = cyc;
    set_slot4(0, base, on, off, cnt, ab);
    on4 = 8'(on); off4 = 8'(off); cnt4 = 8'(cnt); cmd_valid4 = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid4 = 1'b0;
    on4 = 8'($urandom); off4 = 8'($urandom); cnt4 = 8'($urandom);
  endtask

  initial begin
    int b;
    s4[0].v = 0; s4[1].v = 0; s1[0].v = 0; s1[1].v = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", cmd_ready4, 1'b1);
    check("reset_led", led4, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    at_cycle(cyc + 2);

    // asynchronous reset while in the ON phase
    issue4(2, 1, 2, -1, b);
    at_cycle(b + 3);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", led4, 1'b0);
    check("async_rst_busy", busy4, 1'b0);
    check("async_rst_done", done4, 1'b0);
    check("async_rst_aborted", aborted4, 1'b0);
    s4[0].v = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("post_rst_ready", cmd_ready4, 1'b1);
    at_cycle(cyc + 4);

    // basic sequence
    issue4(2, 1, 2, -1, b);
    at_cycle(b + 1);  check("basic_led_c1", led4, 1'b1);
    at_cycle(b + 8);  check("basic_led_c8", led4, 1'b1);
    at_cycle(b + 9);  check("basic_led_c9", led4, 1'b0);
    at_cycle(b + 13); check("basic_led_c13", led4, 1'b1);
    at_cycle(b + 24); check("basic_busy_c24", busy4, 1'b1);
    at_cycle(b + 25); check("basic_done_c25", done4, 1'b1);
    check("basic_busy_c25", busy4, 1'b0);
    at_cycle(b + 28);

    // zero count
    issue4(3, 1, 0, -1, b);
    check("zero_done_c1", done4, 1'b1);
    check("zero_busy_c1", busy4, 1'b0);
    at_cycle(b + 5);

    // off=0 with ignored commands while busy
    issue4(1, 0, 3, -1, b);
    for (int c = b + 2; c <= b + 20; c += 3) begin
      at_cycle(c);
      cmd_valid4 = 1'b1; on4 = 8'd9; off4 = 8'd9; cnt4 = 8'd9;
      @(posedge clk);
      #1 cmd_valid4 = 1'b0;
    end
    at_cycle(b + 24); check("off0_led_c24", led4, 1'b0);
    at_cycle(b + 25); check("off0_done_c25", done4, 1'b1);
    at_cycle(b + 28);

    // abort together with cmd_valid in IDLE: command wins
    abort4 = 1'b1;
    issue4(1, 1, 1, 0, b);
    abort4 = 1'b0;
    check("idle_abort_led", led4, 1'b1);
    at_cycle(b + 9); check("idle_abort_done", done4, 1'b1);
    at_cycle(b + 12);

    // abort mid-sequence
    issue4(5, 5, 10, 6, b);
    at_cycle(b + 6);
    abort4 = 1'b1;
    @(posedge clk);
    #1 abort4 = 1'b0;
    check("abort_led_c7", led4, 1'b0);
    check("abort_pulse_c7", aborted4, 1'b1);
    check("abort_ready_c7", cmd_ready4, 1'b1);
    at_cycle(b + 20);

    // abort on the final OFF tick
    issue4(5, 5, 2, 80, b);
    at_cycle(b + 80);
    check("final_busy_c80", busy4, 1'b1);
    abort4 = 1'b1;
    @(posedge clk);
    #1 abort4 = 1'b0;
    check("final_aborted_c81", aborted4, 1'b1);
    check("final_done_c81", done4, 1'b0);
    at_cycle(b + 86);

    // back-to-back on TICK_DIV=1
    b = cyc;
    s1[0].v = 1; s1[0].base = b;     s1[0].on = 1; s1[0].off = 1; s1[0].cnt = 1; s1[0].ab = -1;
    s1[1].v = 1; s1[1].base = b + 3; s1[1].on = 1; s1[1].off = 1; s1[1].cnt = 1; s1[1].ab = -1;
    on1 = 8'd1; off1 = 8'd1; cnt1 = 8'd1; cmd_valid1 = 1'b1;
    at_cycle(b + 1); check("b2b_led_c1", led1, 1'b1);
    at_cycle(b + 2); check("b2b_led_c2", led1, 1'b0);
    at_cycle(b + 3); check("b2b_done_c3", done1, 1'b1);
    check("b2b_ready_c3", cmd_ready1, 1'b1);
    at_cycle(b + 4);
    cmd_valid1 = 1'b0;
    check("b2b_led_c4", led1, 1'b1);
    at_cycle(b + 6); check("b2b_done_c6", done1, 1'b1);
    at_cycle(b + 10);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
